// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 32 iterations plus a result cycle; MTHI/MTLO complete in one cycle.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [5:0]  op,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0] hi, lo;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        neg_res;
    logic        neg_rem;
    logic        is_div;
    logic        div_zero;

    // One-hot op with left-to-right priority when several bits are set
    logic dec_mult, dec_multu, dec_div, dec_divu, dec_mthi, dec_mtlo;
    assign dec_mult  = op[5];
    assign dec_multu = ~op[5] & op[4];
    assign dec_div   = ~|op[5:4] & op[3];
    assign dec_divu  = ~|op[5:3] & op[2];
    assign dec_mthi  = ~|op[5:2] & op[1];
    assign dec_mtlo  = ~|op[5:1] & op[0];

    logic take;
    logic start_mul, start_div;
    assign take      = (state == IDLE) & in_valid & ~flush;
    assign start_mul = take & (dec_mult | dec_multu);
    assign start_div = take & (dec_div | dec_divu);

    logic        is_signed;
    logic [31:0] abs_rs, abs_rt;
    assign is_signed = dec_mult | dec_div;
    assign abs_rs    = (is_signed & rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    assign abs_rt    = (is_signed & rt_data[31]) ? (32'd0 - rt_data) : rt_data;

    // Multiply step: add shifted multiplicand when the current multiplier bit is set
    logic [63:0] acc_step;
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    // Restoring divide step on a 33-bit trial remainder; the difference always fits in 32 bits
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_step;
    assign trial    = {rem, quo[31]};
    assign q_bit    = trial[32] | (trial[31:0] >= dvsr);
    assign rem_step = q_bit ? (trial[31:0] - dvsr) : trial[31:0];

    // Sign fixes applied in DONE
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_res ? (64'd0 - acc) : acc;
    assign quo_fix  = neg_res ? (32'd0 - quo) : quo;
    assign rem_fix  = neg_rem ? (32'd0 - rem) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_mul)      state_nxt = MUL;
                else if (start_div) state_nxt = DIV;
            end
            MUL, DIV: begin
                if (flush)             state_nxt = IDLE;
                else if (cnt == 6'd31) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_mul) begin
                        mcand   <= {32'd0, abs_rs};
                        mplier  <= abs_rt;
                        acc     <= '0;
                        cnt     <= '0;
                        neg_res <= dec_mult & (rs_data[31] ^ rt_data[31]);
                        neg_rem <= 1'b0;
                        is_div  <= 1'b0;
                    end else if (start_div) begin
                        rem      <= '0;
                        quo      <= abs_rs;
                        dvsr     <= abs_rt;
                        cnt      <= '0;
                        neg_res  <= dec_div & (rs_data[31] ^ rt_data[31]);
                        neg_rem  <= dec_div & rs_data[31];
                        div_zero <= (rt_data == 32'd0);
                        is_div   <= 1'b1;
                    end else if (take & dec_mthi) begin
                        hi <= rs_data;
                    end else if (take & dec_mtlo) begin
                        lo <= rs_data;
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                end
                DIV: begin
                    rem <= rem_step;
                    quo <= {quo[30:0], q_bit};
                    cnt <= cnt + 6'd1;
                end
                DONE: begin
                    if (!flush) begin
                        if (!is_div) begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end else begin
                            // Divide by zero leaves the dividend magnitude in rem, so the
                            // remainder fix reproduces rs exactly; only LO needs overriding.
                            hi <= rem_fix;
                            lo <= div_zero ? 32'hFFFF_FFFF : quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o     = hi;
    assign lo_o     = lo;
    assign busy     = (state != IDLE);
    assign stallreq = start_mul | start_div | (state == MUL) | (state == DIV);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: cycle-level behavioural model (plain 64-bit arithmetic plus a
// busy-cycle countdown) compared every cycle, plus literal expectations for known cases.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  op;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq;
    logic        busy;

    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;

    ex_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .op       (op),
        .flush    (flush),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .stallreq (stallreq),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: architectural HI/LO, pending result, and cycles left until the unit is free
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          left;
    int          stall_cnt;

    // 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 0 none
    function automatic int pick(logic [5:0] o);
        for (int i = 5; i >= 0; i--)
            if (o[i]) return 6 - i;
        return 0;
    endfunction

    function automatic logic [63:0] ref_res(int k, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0]        up;
        longint             sp;
        sa = a;
        sb = b;
        case (k)
            1: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int  k;
        logic es, eb;
        k  = pick(op);
        eb = (left > 0);
        es = (left > 1) || (left == 0 && in_valid && !flush && k >= 1 && k <= 4);
        chk("hi_o", hi_o, m_hi);
        chk("lo_o", lo_o, m_lo);
        chk("stallreq", 32'(stallreq), 32'(es));
        chk("busy", 32'(busy), 32'(eb));
    endtask

    task automatic model_edge();
        int k;
        if (left > 0) begin
            if (flush) left = 0;
            else if (left == 1) begin
                m_hi = p_hi;
                m_lo = p_lo;
                left = 0;
            end else left--;
        end else if (in_valid && !flush) begin
            k = pick(op);
            if (k >= 1 && k <= 4) begin
                {p_hi, p_lo} = ref_res(k, rs_data, rt_data);
                left = 33;
            end else if (k == 5) m_hi = rs_data;
            else if (k == 6) m_lo = rs_data;
        end
    endtask

    task automatic drive(logic v, logic [5:0] o, logic [31:0] a, logic [31:0] b, logic f);
        @(negedge clk);
        in_valid = v;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        flush    = f;
        #1;
        compare();
        if (stallreq) stall_cnt++;
        model_edge();
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 6'($urandom), $urandom, $urandom, 1'b0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = '0;
        flush    = 1'b0;
        rs_data  = '0;
        rt_data  = '0;
        m_hi     = '0;
        m_lo     = '0;
        p_hi     = '0;
        p_lo     = '0;
        left     = 0;
        stall_cnt = 0;
        #2;
        chk("reset_hi", hi_o, 32'd0);
        chk("reset_lo", lo_o, 32'd0);
        chk("reset_stall", 32'(stallreq), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // multu all-ones: 33 stalled cycles
        stall_cnt = 0;
        drive(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle(34);
        chk("multu_stall_cycles", 32'(stall_cnt), 32'd33);
        chk("multu_hi", hi_o, 32'hFFFF_FFFE);
        chk("multu_lo", lo_o, 32'h0000_0001);

        drive(1'b1, OP_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0);
        idle(34);
        chk("mult_neg_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo_o, 32'hFFFF_FFEB);

        drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(34);
        chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);

        drive(1'b1, OP_DIVU, 32'd100, 32'd0, 1'b0);
        idle(34);
        chk("divu_zero_lo", lo_o, 32'hFFFF_FFFF);
        chk("divu_zero_hi", hi_o, 32'd100);

        drive(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(34);
        chk("div_ovf_lo", lo_o, 32'h8000_0000);
        chk("div_ovf_hi", hi_o, 32'd0);

        // mthi then immediate mult
        drive(1'b1, OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("mthi_hi", hi_o, 32'h0000_1234);
        chk("mthi_nostall", 32'(stallreq), 32'd0);
        drive(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
        idle(34);
        chk("mult67_lo", lo_o, 32'd42);
        chk("mult67_hi", hi_o, 32'd0);

        // flush mid-divide, then a fresh divu
        drive(1'b1, OP_DIV, 32'd1000, 32'd7, 1'b0);
        idle(9);
        drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_stall", 32'(stallreq), 32'd0);
        chk("flush_hi", hi_o, 32'd0);
        chk("flush_lo", lo_o, 32'd42);
        drive(1'b1, OP_DIVU, 32'd9, 32'd4, 1'b0);
        idle(34);
        chk("divu94_lo", lo_o, 32'd2);
        chk("divu94_hi", hi_o, 32'd1);

        // asynchronous reset mid-multiply
        drive(1'b1, OP_MULT, 32'd123, 32'd456, 1'b0);
        idle(5);
        rst = 1'b1;
        #1;
        chk("async_rst_hi", hi_o, 32'd0);
        chk("async_rst_lo", lo_o, 32'd0);
        chk("async_rst_stall", 32'(stallreq), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        m_hi = '0;
        m_lo = '0;
        left = 0;
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic: multi-hot ops, ignored inputs while busy, occasional flush
        repeat (4000) begin
            logic       v, f;
            logic [5:0] o;
            v = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            f = ($urandom_range(0, 99) == 0);
            drive(v, o, rand_opnd(), rand_opnd(), f);
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
